alu_seq_exec: RTL and testbench
===============================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, operation request valid.
REQ-004 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-005 SHALL have port alu_operation, input, ALU_OP_WIDTH (10), one-hot op vector indexed by the OP_DECINFO_* bit positions (ADD, SUB, XOR, SLL, SRL, SRA, OR, AND, SLT, SLTU).
REQ-006 SHALL have ports op1, op2, input, DATA_WIDTH (32) each, source operands.
REQ-007 SHALL have port flush, input, 1, synchronous kill of any in-flight operation.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port result, output, DATA_WIDTH, operation result.
REQ-011 SHALL have port zero, output, 1, result == 0, for branch resolution.
REQ-012 SHALL have port illegal_op, output, 1, present only when ALU_ONEHOT_CHECK_EN is defined.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; a request is accepted on a cycle with in_valid & in_ready & ~flush.
REQ-015 SHALL, for non-shift ops, register the result and enter DONE, so out_valid rises on the cycle after acceptance (latency 1).
REQ-016 SHALL compute ADD/SUB modulo 2^32, XOR/OR/AND bitwise, SLT signed and SLTU unsigned compare as {31'b0, lt}.
REQ-017 SHALL, for SLL/SRL/SRA, latch op1 and shamt = op2[4:0], and with shamt = 0 go straight to DONE with result = op1.
REQ-018 SHALL, for shamt = k > 0, shift one bit per cycle in SHIFT with a 5-bit down-counter, entering DONE after k shift cycles; out_valid rises k+1 cycles after acceptance.
REQ-019 SHALL shift in zeros for SLL/SRL and copies of bit 31 for SRA.
REQ-020 SHALL hold result, zero and out_valid stable in DONE while out_ready = 0.
REQ-021 SHALL return to IDLE on out_valid & out_ready; a new request is not accepted in that same cycle.
REQ-022 SHALL, on flush in SHIFT or DONE, go to IDLE next cycle with out_valid = 0 and the result discarded; flush has priority over out_ready and in_valid.
REQ-023 SHALL ignore alu_operation, op1 and op2 outside the accept cycle.

Reset
REQ-024 SHALL on rst enter IDLE and clear the counter, result, zero (result = 0 and zero = 1 are the reset values), out_valid and illegal_op; in_ready = 1 after reset.
REQ-025 SHALL abort any in-flight operation on rst mid-operation without producing out_valid.

Configuration
REQ-026 SHALL, with ALU_ONEHOT_CHECK_EN defined, treat an alu_operation that is not exactly one-hot (zero or multiple bits set) as illegal: latency 1, result = 0, zero = 1, illegal_op = 1 while in DONE.
REQ-027 SHALL, without ALU_ONEHOT_CHECK_EN, omit illegal_op and resolve non-one-hot vectors by lowest set bit index; an all-zero vector gives result = 0 at latency 1.

Structure
REQ-028 SHALL take DATA_WIDTH, ALU_OP_WIDTH, the OP_DECINFO_* indices and the FSM state encodings from the shared include.v.
REQ-029 SHALL place the iterative shifter (register plus counter) in the sub-module alu_serial_shifter; the single-cycle ops stay in alu_seq_exec.

Verification
REQ-030 SHALL cover: ADD op1 = 0x7FFFFFFF, op2 = 1 -> result 0x80000000 with out_valid one cycle after accept.
REQ-031 SHALL cover: SRA op1 = 0x80000000, op2 = 31 -> result 0xFFFFFFFF with out_valid 32 cycles after accept; SLL with op2 = 0x20 (shamt 0) -> result = op1 at latency 1.
REQ-032 SHALL cover: SLT op1 = 0xFFFFFFFF, op2 = 1 -> 1; SLTU with the same operands -> 0; SUB 5 - 5 -> 0 with zero = 1.
REQ-033 SHALL cover: out_ready held 0 for 3 cycles -> result held stable and in_ready = 0 throughout; release -> IDLE on the next cycle.
REQ-034 SHALL cover: flush at the 4th cycle of SRL with shamt 10 -> IDLE next cycle, no out_valid; rst asserted mid-shift -> IDLE immediately.
REQ-035 SHALL cover, with ALU_ONEHOT_CHECK_EN: alu_operation = 0x003 -> illegal_op = 1, result = 0 at latency 1; without the macro, the same vector -> the op at the lowest set bit index.

Source files
------------

// File: rtl/alu_seq_exec_pkg.sv
// Shared definitions for the sequential ALU: data/op widths, one-hot op bit
// positions, FSM state encodings and serial shift kinds.
// The optional ALU_ONEHOT_CHECK_EN macro (used by alu_seq_exec) enables
// strict one-hot checking of the op vector.
package alu_seq_exec_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 10;
    localparam int SHAMT_WIDTH  = 5;

    // Bit positions inside the one-hot alu_operation vector
    localparam int OP_DECINFO_ADD  = 0;
    localparam int OP_DECINFO_SUB  = 1;
    localparam int OP_DECINFO_XOR  = 2;
    localparam int OP_DECINFO_SLL  = 3;
    localparam int OP_DECINFO_SRL  = 4;
    localparam int OP_DECINFO_SRA  = 5;
    localparam int OP_DECINFO_OR   = 6;
    localparam int OP_DECINFO_AND  = 7;
    localparam int OP_DECINFO_SLT  = 8;
    localparam int OP_DECINFO_SLTU = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    // Serial shift direction / fill selection
    localparam logic [1:0] SHK_SLL = 2'd0;
    localparam logic [1:0] SHK_SRL = 2'd1;
    localparam logic [1:0] SHK_SRA = 2'd2;

    // Isolate the lowest set bit of the op vector (two's complement trick)
    function automatic logic [ALU_OP_WIDTH-1:0] lowest_set(input logic [ALU_OP_WIDTH-1:0] v);
        return v & (-v);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative one-bit-per-cycle shifter: holds the operand being shifted and a
// down-counter of remaining steps. The owner decides when the last step is
// taken and captures data_next on that cycle.
module alu_serial_shifter
    import alu_seq_exec_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic [SHAMT_WIDTH-1:0] load_shamt,
    input  logic [1:0]             load_kind,
    input  logic                   step,
    output logic [DATA_WIDTH-1:0]  data_next,
    output logic                   last
);

    logic [DATA_WIDTH-1:0]  data_reg;
    logic [SHAMT_WIDTH-1:0] count_reg;
    logic [1:0]             kind_reg;

    // One-bit shift of the held value; SRA replicates the sign bit
    always_comb begin
        data_next = data_reg;
        case (kind_reg)
            SHK_SLL: data_next = {data_reg[DATA_WIDTH-2:0], 1'b0};
            SHK_SRL: data_next = {1'b0, data_reg[DATA_WIDTH-1:1]};
            SHK_SRA: data_next = {data_reg[DATA_WIDTH-1], data_reg[DATA_WIDTH-1:1]};
            default: data_next = data_reg;
        endcase
    end

    assign last = (count_reg == 5'd1);

    // Load operand/count on accept, then step down one bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            count_reg <= '0;
            kind_reg  <= SHK_SLL;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            data_reg  <= load_data;
            count_reg <= load_shamt;
            kind_reg  <= load_kind;
        end else if (step && (count_reg != 5'd0)) begin
            data_reg  <= data_next;
            count_reg <= count_reg - 5'd1;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU execute unit. Single-cycle ops complete with latency 1;
// shifts run serially (one bit per cycle) in alu_serial_shifter.
// Optional macro ALU_ONEHOT_CHECK_EN: reject non-one-hot op vectors and
// expose illegal_op. Without it, the lowest set op bit wins.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ALU_OP_WIDTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]   op1,
    input  logic [DATA_WIDTH-1:0]   op2,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
`ifdef ALU_ONEHOT_CHECK_EN
    output logic                    illegal_op,
`endif
    output logic                    zero
);

    alu_state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0]   result_reg;
    logic                    zero_reg;
    logic [ALU_OP_WIDTH-1:0] op_sel;
    logic                    op_illegal;
    logic                    is_shift;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic [1:0]              shift_kind;
    logic                    accept;
    logic                    go_shift;
    logic                    shift_done;
    logic                    shift_last;
    logic [DATA_WIDTH-1:0]   shift_data_next;
    logic [DATA_WIDTH-1:0]   alu_comb;
    logic [DATA_WIDTH-1:0]   accept_result;

    assign op_sel = lowest_set(alu_operation);
    assign shamt  = op2[SHAMT_WIDTH-1:0];

`ifdef ALU_ONEHOT_CHECK_EN
    assign op_illegal = (alu_operation == '0) || (op_sel != alu_operation);
`else
    assign op_illegal = 1'b0;
`endif

    assign is_shift   = op_sel[OP_DECINFO_SLL] | op_sel[OP_DECINFO_SRL] | op_sel[OP_DECINFO_SRA];
    assign shift_kind = op_sel[OP_DECINFO_SLL] ? SHK_SLL :
                        op_sel[OP_DECINFO_SRL] ? SHK_SRL : SHK_SRA;

    assign accept     = (state_reg == ST_IDLE) && in_valid && !flush;
    assign go_shift   = is_shift && !op_illegal && (shamt != '0);
    assign shift_done = (state_reg == ST_SHIFT) && !flush && shift_last;

    // Single-cycle result; a shift with zero amount simply passes op1
    always_comb begin
        alu_comb = '0;
        if (op_sel[OP_DECINFO_ADD])  alu_comb = op1 + op2;
        if (op_sel[OP_DECINFO_SUB])  alu_comb = op1 - op2;
        if (op_sel[OP_DECINFO_XOR])  alu_comb = op1 ^ op2;
        if (op_sel[OP_DECINFO_OR])   alu_comb = op1 | op2;
        if (op_sel[OP_DECINFO_AND])  alu_comb = op1 & op2;
        if (op_sel[OP_DECINFO_SLT])  alu_comb = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
        if (op_sel[OP_DECINFO_SLTU]) alu_comb = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
        if (is_shift)                alu_comb = op1;
    end

    assign accept_result = op_illegal ? '0 : alu_comb;

    alu_serial_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .load       (accept && go_shift),
        .load_data  (op1),
        .load_shamt (shamt),
        .load_kind  (shift_kind),
        .step       (state_reg == ST_SHIFT),
        .data_next  (shift_data_next),
        .last       (shift_last)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs; flush outranks out_ready and in_valid
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = go_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (shift_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture result and zero flag at accept (single-cycle) or last shift step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            zero_reg   <= 1'b1;
        end else if (accept && !go_shift) begin
            result_reg <= accept_result;
            zero_reg   <= (accept_result == '0);
        end else if (shift_done) begin
            result_reg <= shift_data_next;
            zero_reg   <= (shift_data_next == '0);
        end
    end

`ifdef ALU_ONEHOT_CHECK_EN
    logic illegal_reg;

    // Illegal flag is set on accept and dropped when DONE is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (accept) begin
            illegal_reg <= op_illegal;
        end else if ((state_reg == ST_DONE) && (flush || out_ready)) begin
            illegal_reg <= 1'b0;
        end
    end

    assign illegal_op = illegal_reg;
`endif

    assign result = result_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Testbench for alu_seq_exec: table of directed vectors plus hand-written
// sequences for stall, flush and reset-in-flight corner cases.
// Honours ALU_ONEHOT_CHECK_EN when the design is built with it.
module tb_alu_seq_exec;
    import alu_seq_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  alu_operation = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_ONEHOT_CHECK_EN
    logic        illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_exec dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_operation (alu_operation),
        .op1           (op1),
        .op2           (op2),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
`ifdef ALU_ONEHOT_CHECK_EN
        .illegal_op    (illegal_op),
`endif
        .zero          (zero)
    );

    typedef struct packed {
        logic [9:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        logic [7:0]  exp_lat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic logic [9:0] oh(input int idx);
        logic [9:0] one;
        one = 10'd1;
        return one << idx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request, then wait (bounded) for out_valid; inputs are
    // scrambled after the accept cycle since the unit must ignore them.
    task automatic run_op(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat);
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        alu_operation = op;
        op1 = a;
        op2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        alu_operation = 10'($urandom);
        op1 = $urandom;
        op2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        z = zero;
    endtask

    // Consume the result (call at a negedge with out_valid high)
    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat;
        int          seen;

        vecs[0]  = '{oh(OP_DECINFO_ADD),  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 8'd1};
        vecs[1]  = '{oh(OP_DECINFO_SRA),  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 1'b0, 8'd32};
        vecs[2]  = '{oh(OP_DECINFO_SLL),  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 8'd1};
        vecs[3]  = '{oh(OP_DECINFO_SLT),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 8'd1};
        vecs[4]  = '{oh(OP_DECINFO_SLTU), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{oh(OP_DECINFO_SUB),  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{oh(OP_DECINFO_XOR),  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{oh(OP_DECINFO_OR),   32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{oh(OP_DECINFO_AND),  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{oh(OP_DECINFO_SLL),  32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0, 1'b0, 8'd5};
        vecs[10] = '{oh(OP_DECINFO_SRL),  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 8'd5};
        vecs[11] = '{oh(OP_DECINFO_SRA),  32'hF000_0000, 32'd4,         32'hFF00_0000, 1'b0, 1'b0, 8'd5};
        vecs[12] = '{oh(OP_DECINFO_SLL),  32'hFFFF_FFFF, 32'h0000_0021, 32'hFFFF_FFFE, 1'b0, 1'b0, 8'd2};
`ifdef ALU_ONEHOT_CHECK_EN
        vecs[13] = '{10'h003,             32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 8'd1};
        vecs[14] = '{10'h000,             32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 8'd1};
`else
        vecs[13] = '{10'h003,             32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{10'h000,             32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 8'd1};
`endif
        vecs[15] = '{oh(OP_DECINFO_SUB),  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  {31'b0, in_ready},  32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result",    result,             32'd0);
        check("reset_zero",      {31'b0, zero},      32'd1);
        $display("txn reset: in_ready=%0b out_valid=%0b result=%h zero=%0b", in_ready, out_valid, result, zero);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            $display("txn vec%0d: op=%h a=%h b=%h -> result=%h zero=%0b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), {31'b0, z}, {31'b0, vecs[i].exp_zero});
            check($sformatf("vec%0d_latency", i), 32'(lat), {24'b0, vecs[i].exp_lat});
`ifdef ALU_ONEHOT_CHECK_EN
            check($sformatf("vec%0d_illegal", i), {31'b0, illegal_op}, {31'b0, vecs[i].exp_ill});
`endif
            drain();
        end

        // Stall: out_ready low for 3 cycles, then release with a competing request
        run_op(oh(OP_DECINFO_ADD), 32'd3, 32'd4, res, z, lat);
        check("stall_first", res, 32'd7);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_result_c%0d", c), result, 32'd7);
            check($sformatf("stall_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_operation = oh(OP_DECINFO_ADD);
        op1 = 32'd1;
        op2 = 32'd1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", {31'b0, out_valid}, 32'd0);
        check("release_in_ready",  {31'b0, in_ready},  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("post_release_valid",  {31'b0, out_valid}, 32'd1);
        check("post_release_result", result, 32'd2);
        $display("txn stall: held 3 cycles, follow-up result=%h", result);
        drain();

        // Flush in the 4th shift cycle of SRL by 10
        @(negedge clk);
        alu_operation = oh(OP_DECINFO_SRL);
        op1 = 32'hFFFF_0000;
        op2 = 32'd10;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready",  {31'b0, in_ready},  32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        $display("txn flush_shift: out_valid pulses after flush=%0d", seen);

        // Recovery after flush: SRL by 8
        run_op(oh(OP_DECINFO_SRL), 32'hFFFF_0000, 32'd8, res, z, lat);
        check("after_flush_result",  res, 32'h00FF_FF00);
        check("after_flush_latency", 32'(lat), 32'd9);
        $display("txn after_flush: result=%h lat=%0d", res, lat);
        drain();

        // Flush while DONE outranks out_ready
        run_op(oh(OP_DECINFO_ADD), 32'd1, 32'd2, res, z, lat);
        check("done_flush_pre", res, 32'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        check("done_flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("done_flush_in_ready",  {31'b0, in_ready},  32'd1);
        $display("txn flush_done: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        // Asynchronous reset mid-shift
        @(negedge clk);
        alu_operation = oh(OP_DECINFO_SLL);
        op1 = 32'd1;
        op2 = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_result",    result,             32'd0);
        check("rst_mid_zero",      {31'b0, zero},      32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid_no_result", 32'(seen), 32'd0);
        $display("txn reset_mid_shift: out_valid pulses after reset=%0d", seen);

        // Recovery after reset: SRA by 1
        run_op(oh(OP_DECINFO_SRA), 32'h8000_0002, 32'd1, res, z, lat);
        check("after_rst_result",  res, 32'hC000_0001);
        check("after_rst_latency", 32'(lat), 32'd2);
        $display("txn after_reset: result=%h lat=%0d", res, lat);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
